// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared constants and types for the CORDIC blocks (rotation and vectoring).
//   ATAN_TABLE : atan(2^-i) in 32-bit binary-angle units (2^32 = 2*pi), i=0..15
//   ANGLE_PI_2 : pi/2 in the same units
//   cordic_state_t : control states of the iterative vectoring engine
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam int ATAN_ENTRIES = 16;

    localparam logic [31:0] ANGLE_PI_2 = 32'h4000_0000;

    localparam logic [31:0] ATAN_TABLE [ATAN_ENTRIES] = '{
        32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cordic_state_t;

endpackage : cordic_pkg

// File: rtl/cordic_vec_step.sv
// -----------------------------------------------------------------------------
// cordic_vec_step
// One combinational vectoring micro-rotation. The sign of y selects the
// rotation direction that drives y towards zero; z accumulates the angle
// rotated so far.
//   x, y     : current vector (signed, W bits)
//   z        : current accumulated angle (32-bit binary angle)
//   i        : iteration index, selects shift amount and atan entry
//   x_next, y_next, z_next : vector and angle after this micro-rotation
// -----------------------------------------------------------------------------
module cordic_vec_step
    import cordic_pkg::*;
#(
    parameter int W = 10
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic        [31:0]  z,
    input  logic        [3:0]   i,
    output logic signed [W-1:0] x_next,
    output logic signed [W-1:0] y_next,
    output logic        [31:0]  z_next
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;

    // Arithmetic shifts: negative values round towards minus infinity.
    assign x_sh = x >>> i;
    assign y_sh = y >>> i;

    always_comb begin
        if (!y[W-1]) begin
            // y >= 0: rotate clockwise, the phase grows.
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + ATAN_TABLE[i];
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - ATAN_TABLE[i];
        end
    end

endmodule : cordic_vec_step

// File: rtl/cordic_vector_8.sv
// -----------------------------------------------------------------------------
// cordic_vector_8
// Iterative CORDIC vectoring engine: (Xin, Yin) -> (K*|v|, atan2(Yin, Xin)).
// One micro-rotation per clock, STG micro-rotations per vector.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : input handshake, Xin/Yin captured on acceptance
//   Xin, Yin            : signed input vector
//   out_valid/out_ready : output handshake
//   Mag                 : magnitude scaled by the CORDIC gain K (unsigned)
//   Phase               : 32-bit binary angle, 0x40000000 = pi/2
// -----------------------------------------------------------------------------
module cordic_vector_8
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int STG       = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] Xin,
    input  logic signed [BIT_WIDTH-1:0] Yin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic        [BIT_WIDTH+1:0] Mag,
    output logic        [31:0]          Phase
);

    // Two guard bits: one for negating the most negative input, one for the
    // CORDIC gain (|X| stays below 2^(BIT_WIDTH+1)).
    localparam int W     = BIT_WIDTH + 2;
    localparam int CNT_W = (STG > 1) ? $clog2(STG) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(STG - 1);

    cordic_state_t state_q;
    cordic_state_t state_d;

    logic signed [W-1:0] x_q;
    logic signed [W-1:0] y_q;
    logic        [31:0]  z_q;
    logic [CNT_W-1:0]    cnt_q;

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] y_ext;
    logic signed [W-1:0] x_load;
    logic signed [W-1:0] y_load;
    logic        [31:0]  z_load;

    logic signed [W-1:0] x_step;
    logic signed [W-1:0] y_step;
    logic        [31:0]  z_step;

    logic accept;
    logic last_iter;

    // ------------------------------------------------------------------
    // Pre-rotation into the right half-plane by +/- pi/2 so the
    // micro-rotations only have to cover +/- ~99.9 degrees.
    // ------------------------------------------------------------------
    assign x_ext = W'(Xin);
    assign y_ext = W'(Yin);

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
        x_load = x_ext;
        y_load = y_ext;
        z_load = '0;
        if (x_ext[W-1]) begin
            if (!y_ext[W-1]) begin
                x_load = y_ext;
                y_load = -x_ext;
                z_load = ANGLE_PI_2;
            end else begin
                x_load = -y_ext;
                y_load = x_ext;
                z_load = -ANGLE_PI_2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Single shared micro-rotation, stepped by the iteration counter.
    // ------------------------------------------------------------------
    cordic_vec_step #(
        .W (W)
    ) u_step (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .i      (4'(cnt_q)),
        .x_next (x_step),
        .y_next (y_step),
        .z_next (z_step)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign last_iter = (cnt_q == LAST_ITER);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers. X and Z double as the result registers: they are
    // frozen outside BUSY, so Mag/Phase hold until the next acceptance.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            x_q   <= x_load;
            y_q   <= y_load;
            z_q   <= z_load;
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            x_q   <= x_step;
            y_q   <= y_step;
            z_q   <= z_step;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    // X is non-negative after pre-rotation, so its bits read as unsigned.
    assign Mag       = x_q[W-1:0];
    assign Phase     = z_q;

endmodule : cordic_vector_8

// File: tb/tb_cordic_vector_8.sv
// -----------------------------------------------------------------------------
// tb_cordic_vector_8
// Self-checking bench for cordic_vector_8. Expected results come from an
// ideal floating-point model: Phase = atan2(Yin, Xin) in binary-angle units
// and Mag = K * sqrt(Xin^2 + Yin^2), compared within the CORDIC tolerances.
// -----------------------------------------------------------------------------
module tb_cordic_vector_8;

    localparam int BW        = 8;
    localparam int STG       = 8;
    localparam int MAG_TOL   = 3;
    localparam int PHASE_TOL = 1 << 25;
    localparam int WAIT_MAX  = 40;

    localparam int DX [5] = '{100,    0,    0, -100, -128};
    localparam int DY [5] = '{  0,  100, -100,    0, -128};

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [BW-1:0] Xin;
    logic signed [BW-1:0] Yin;
    logic                 out_valid;
    logic                 out_ready;
    logic [BW+1:0]        Mag;
    logic [31:0]          Phase;

    int checks;
    int failures;

    cordic_vector_8 #(
        .BIT_WIDTH (BW),
        .STG       (STG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xin       (Xin),
        .Yin       (Yin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Mag       (Mag),
        .Phase     (Phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic real cordic_gain();
        real g = 1.0;
        real p = 1.0;
        for (int i = 0; i < STG; i++) begin
            g = g * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        return g;
    endfunction

    function automatic int model_mag(input int xi, input int yi);
        real r = $sqrt(real'(xi * xi + yi * yi));
        return int'(cordic_gain() * r);
    endfunction

    function automatic logic [31:0] model_phase(input int xi, input int yi);
        real    a = $atan2(real'(yi), real'(xi));
        real    u = a * 4294967296.0 / (2.0 * 3.14159265358979323846);
        longint l = longint'(u);
        if (l < 0) l = l + 64'sd4294967296;
        return l[31:0];
    endfunction

    function automatic bit phase_close(input logic [31:0] act, input logic [31:0] exp_ph);
        int d = int'(act - exp_ph);
        return (d <= PHASE_TOL) && (d >= -PHASE_TOL);
    endfunction

    function automatic bit mag_close(input logic [BW+1:0] act, input int exp_mag);
        int d = int'(act) - exp_mag;
        return (d <= MAG_TOL) && (d >= -MAG_TOL);
    endfunction

    // Random vector, kept away from the origin where the quantised
    // angle resolution is coarser than the phase tolerance.
    task automatic rand_vector(output int xi, output int yi);
        do begin
            xi = int'($urandom_range(255, 0)) - 128;
            yi = int'($urandom_range(255, 0)) - 128;
        end while (xi * xi + yi * yi < 8100);
    endtask

    // Push one vector through in isolation: accept, wait for the result,
    // then complete the output handshake.
    task automatic run_vector(input int xi, input int yi,
                              output logic [BW+1:0] mag, output logic [31:0] ph,
                              output int lat, output bit ready_ok, output bit idle_ok);
        @(negedge clk);
        ready_ok = in_ready;
        Xin      = BW'(xi);
        Yin      = BW'(yi);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat <= WAIT_MAX) begin
            @(posedge clk);
            #1 lat++;
        end
        mag = Mag;
        ph  = Phase;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        idle_ok = in_ready && !out_valid;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Mag !== '0 || Phase !== '0) begin
            failures++;
            $display("FAIL por_state: in_ready=%b out_valid=%b Mag=%0d Phase=%h, expected 1 0 0 00000000",
                     in_ready, out_valid, Mag, Phase);
        end
        @(negedge clk) rst_n = 1'b1;

        // Reset mid-computation must discard the vector.
        @(negedge clk);
        Xin = BW'(100); Yin = '0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Mag !== '0 || Phase !== '0) begin
            failures++;
            $display("FAIL busy_reset: in_ready=%b out_valid=%b Mag=%0d Phase=%h, expected 1 0 0 00000000",
                     in_ready, out_valid, Mag, Phase);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_discard: out_valid_seen=%b in_ready=%b, expected 0 1", seen, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [BW+1:0] mag;
        logic [31:0]   ph;
        int            lat;
        bit            rdy, idl;
        for (int k = 0; k < 5; k++) begin
            run_vector(DX[k], DY[k], mag, ph, lat, rdy, idl);
            checks++;
            if (lat != STG || !rdy) begin
                failures++;
                $display("FAIL dir_latency(%0d,%0d): latency=%0d in_ready=%b, expected %0d 1",
                         DX[k], DY[k], lat, rdy, STG);
            end
            checks++;
            if (!phase_close(ph, model_phase(DX[k], DY[k]))) begin
                failures++;
                $display("FAIL dir_phase(%0d,%0d): got %h, expected %h +/- 2^25",
                         DX[k], DY[k], ph, model_phase(DX[k], DY[k]));
            end
            checks++;
            if (!mag_close(mag, model_mag(DX[k], DY[k]))) begin
                failures++;
                $display("FAIL dir_mag(%0d,%0d): got %0d, expected %0d +/- %0d",
                         DX[k], DY[k], mag, model_mag(DX[k], DY[k]), MAG_TOL);
            end
            checks++;
            if (!idl) begin
                failures++;
                $display("FAIL dir_idle(%0d,%0d): in_ready/out_valid after handshake wrong, expected 1/0",
                         DX[k], DY[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int            xi, yi, lat;
        logic [BW+1:0] mag0;
        logic [31:0]   ph0;
        bit            stable;
        rand_vector(xi, yi);
        @(negedge clk);
        Xin = BW'(xi); Yin = BW'(yi); in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat <= WAIT_MAX) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++;
        if (lat != STG) begin
            failures++;
            $display("FAIL bp_latency: latency=%0d, expected %0d", lat, STG);
        end
        mag0 = Mag;
        ph0  = Phase;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = c[0] ? 1'b0 : 1'b1;
            Xin = BW'($urandom);
            Yin = BW'($urandom);
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Mag !== mag0 || Phase !== ph0)
                stable = 1'b0;
        end
        @(negedge clk) in_valid = 1'b0;
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL bp_hold: outputs changed under backpressure (now out_valid=%b in_ready=%b Mag=%0d Phase=%h)",
                     out_valid, in_ready, Mag, Phase);
        end
        checks++;
        if (!phase_close(ph0, model_phase(xi, yi)) || !mag_close(mag0, model_mag(xi, yi))) begin
            failures++;
            $display("FAIL bp_result(%0d,%0d): got Mag=%0d Phase=%h, expected Mag=%0d Phase=%h",
                     xi, yi, mag0, ph0, model_mag(xi, yi), model_phase(xi, yi));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Mag !== mag0 || Phase !== ph0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b Mag=%0d Phase=%h, expected 1 0 %0d %h",
                     in_ready, out_valid, Mag, Phase, mag0, ph0);
        end
    endtask

    task automatic test_random();
        int            xi, yi, lat;
        logic [BW+1:0] mag;
        logic [31:0]   ph;
        bit            rdy, idl;
        for (int k = 0; k < 12; k++) begin
            rand_vector(xi, yi);
            run_vector(xi, yi, mag, ph, lat, rdy, idl);
            checks++;
            if (lat != STG || !rdy || !idl) begin
                failures++;
                $display("FAIL rnd_timing(%0d,%0d): latency=%0d ready=%b idle=%b, expected %0d 1 1",
                         xi, yi, lat, rdy, idl, STG);
            end
            checks++;
            if (!phase_close(ph, model_phase(xi, yi)) || !mag_close(mag, model_mag(xi, yi))) begin
                failures++;
                $display("FAIL rnd_result(%0d,%0d): got Mag=%0d Phase=%h, expected Mag=%0d Phase=%h",
                         xi, yi, mag, ph, model_mag(xi, yi), model_phase(xi, yi));
            end
        end
    endtask

    task automatic test_back_to_back();
        int            vx [4];
        int            vy [4];
        int            acc_cyc [$];
        logic [BW+1:0] smag [$];
        logic [31:0]   sph [$];
        int            nxt, cyc, lat;
        logic [BW+1:0] imag;
        logic [31:0]   iph;
        bit            rdy, idl;
        for (int k = 0; k < 4; k++) rand_vector(vx[k], vy[k]);
        nxt = 0;
        cyc = 0;
        while (smag.size() < 4 && cyc < 100) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (nxt < 4) begin
                in_valid = 1'b1;
                Xin = BW'(vx[nxt]);
                Yin = BW'(vy[nxt]);
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                nxt++;
            end
            if (out_valid && out_ready) begin
                smag.push_back(Mag);
                sph.push_back(Phase);
            end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (smag.size() != 4 || acc_cyc.size() != 4) begin
            failures++;
            $display("FAIL stream_count: results=%0d accepts=%0d, expected 4 4", smag.size(), acc_cyc.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (acc_cyc[k] - acc_cyc[k-1] != STG + 2) begin
                    failures++;
                    $display("FAIL stream_period[%0d]: %0d cycles, expected %0d",
                             k, acc_cyc[k] - acc_cyc[k-1], STG + 2);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (!phase_close(sph[k], model_phase(vx[k], vy[k])) ||
                    !mag_close(smag[k], model_mag(vx[k], vy[k]))) begin
                    failures++;
                    $display("FAIL stream_result[%0d]: got Mag=%0d Phase=%h, expected Mag=%0d Phase=%h",
                             k, smag[k], sph[k], model_mag(vx[k], vy[k]), model_phase(vx[k], vy[k]));
                end
                run_vector(vx[k], vy[k], imag, iph, lat, rdy, idl);
                checks++;
                if (imag !== smag[k] || iph !== sph[k]) begin
                    failures++;
                    $display("FAIL stream_vs_isolated[%0d]: stream Mag=%0d Phase=%h, isolated Mag=%0d Phase=%h",
                             k, smag[k], sph[k], imag, iph);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Xin       = '0;
        Yin       = '0;

        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cordic_vector_8

// File: doc/cordic_vector_8.md
# cordic_vector_8

Iterative CORDIC vectoring engine. It is the inverse of the pipelined rotation CORDIC: it takes a Cartesian vector (Xin, Yin) and returns its gain-scaled magnitude and its phase. The phase uses the same 32-bit binary-angle format as the rotation block (2^32 = 2π), so a Phase result can be fed straight back as a rotation `angle`. One micro-rotation per clock; valid/ready handshakes on both sides.

## Interface
- BIT_WIDTH, 8, input sample width (signed)
- STG, 8, number of micro-rotations; legal range 1..16
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- Xin  in  BIT_WIDTH  signed X component
- Yin  in  BIT_WIDTH  signed Y component
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- Mag  out  BIT_WIDTH+2  unsigned magnitude × K (K≈1.6468 for STG=8), not gain-compensated
- Phase  out  32  signed binary angle; 0x40000000 = π/2

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Load X, Y (signed BIT_WIDTH+2) and Z (32-bit) with the pre-rotated vector.
  - Clear the iteration counter and go to BUSY.
- Pre-rotation into the right half-plane:
  - Xin≥0: X=Xin, Y=Yin, Z=0.
  - Xin<0, Yin≥0: X=Yin, Y=−Xin, Z=+0x40000000.
  - Xin<0, Yin<0: X=−Yin, Y=Xin, Z=−0x40000000 (0xC0000000).
- BUSY, iteration i (i = counter, 0..STG−1), using arithmetic shifts of the current registers:
  - Y≥0: X+=Y>>>i, Y−=X>>>i, Z+=atan[i].
  - Y<0: X−=Y>>>i, Y+=X>>>i, Z−=atan[i].
  - After i=STG−1, go to DONE.
- DONE:
  - out_valid=1, Mag=X[BIT_WIDTH+1:0], Phase=Z.
  - On out_ready, go to IDLE.
- Z uses wrap-around 32-bit arithmetic. ±π both encode as 0x80000000; the bench compares Phase modulo 2^32.
- Width: |X| ≤ √2·2^(BIT_WIDTH−1)·K < 2^(BIT_WIDTH+1), so no datapath overflow. Xin=−128 is negated without overflow because the datapath is 2 bits wider than the input.
- Zero vector (0,0): Mag=0; Phase is deterministic but not checked.
- in_ready=0 in BUSY and DONE. in_valid and Xin/Yin are ignored there.

## Timing
- Reset (rst_n=0 at a clock edge, in any state): state=IDLE, in_ready=1, out_valid=0, Mag=0, Phase=0, counter=0. Any in-flight vector is discarded.
- Accept at edge t0. Iterations run at edges t1..tSTG. out_valid rises after edge tSTG, i.e. STG cycles after acceptance.
- Mag and Phase are stable and out_valid stays high until the out_ready handshake. They are held from DONE until the next acceptance.
- Return to IDLE on the out_ready edge. The next acceptance is possible at the following edge, so the minimum issue period is STG+2 cycles.
- out_ready asserted before out_valid has no effect.

## Structure
- Package `cordic_pkg`:
  - `ATAN_TABLE`: 16×32-bit constants, entry i = round(atan(2^−i)·2^32/2π). Entries 0..7 are 0x20000000, 0x12E4051D, 0x09FB385B, 0x051111D4, 0x028B0D43, 0x0145D7E1, 0x00A2F61E, 0x00517C55.
  - `ANGLE_PI_2` = 0x40000000.
  - The state enum type.
- The rotation block migrates to `ATAN_TABLE` from the same package.
- One sub-module: `cordic_vec_step`, a combinational single micro-rotation (X, Y, Z, i → X', Y', Z'). It is instantiated once and driven by the counter.

## Test plan
Phase tolerance is ±2^25; Mag tolerance is ±3.
- Reset: drive (100,0), assert rst_n=0 for 2 cycles mid-BUSY → in_ready=1, out_valid=0, Mag=0, Phase=0; no result ever emerges.
- (100,0) → out_valid exactly 8 cycles after accept, Phase≈0x00000000, Mag≈165.
- (0,100) → Phase≈0x40000000; (0,−100) → Phase≈0xC0000000; both Mag≈165.
- (−100,0) → Phase≈0x80000000 (mod 2^32); (−128,−128) → Phase≈0xA0000000, Mag≈298.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid, Mag and Phase stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next cycle.
- Streaming 4 vectors with in_valid=1 and out_ready=1 → accepts exactly every 10 cycles, results in order and each matching its isolated run.
